// File: rtl/lpf_pkg.sv
// rtl/lpf_pkg.sv - shared widths and round/saturate helpers for the low-pass filter output stages
// Contents:
//   IN_W, OUT_W, SHIFT  default filter output width, output word width, and rounding shift
//   OUT_MAX, OUT_MIN    clamp limits for an OUT_W-bit signed word
//   round_shift         adds half an LSB, then shifts right arithmetically (round half toward +inf)
//   round_clamps        1 when the rounded value falls outside the out_w-bit signed range
//   round_sat           rounded value clamped to the out_w-bit signed range
package lpf_pkg;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT   = 7;
    localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_W - 1));

    // A 32-bit int is wide enough for the IN_W+1 bit intermediate of any
    // filter width up to 30 bits, so one helper serves every stage.
    function automatic int round_shift(input int x, input int shift);
        return (x + (1 << (shift - 1))) >>> shift;
    endfunction

    function automatic logic round_clamps(input int x, input int shift, input int out_w);
        int r;
        r = round_shift(x, shift);
        return (r > (1 << (out_w - 1)) - 1) || (r < -(1 << (out_w - 1)));
    endfunction

    function automatic int round_sat(input int x, input int shift, input int out_w);
        int r;
        r = round_shift(x, shift);
        if (r > (1 << (out_w - 1)) - 1) begin
            r = (1 << (out_w - 1)) - 1;
        end else if (r < -(1 << (out_w - 1))) begin
            r = -(1 << (out_w - 1));
        end
        return r;
    endfunction

endpackage

// File: rtl/lpf_decim_out_sync_fifo.sv
// rtl/lpf_decim_out_sync_fifo.sv - synchronous FIFO with extra-MSB pointers
// Ports:
//   clk, rst      clock and synchronous active-high reset (empties the FIFO)
//   push, din     write din; the caller never pushes while full unless it also pops
//   pop           drop the head entry; the caller never pops while empty
//   dout          head entry (undefined while empty)
//   full, empty   occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Equal indices: MSBs equal means empty, MSBs differing means the writer lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/lpf_decim_out.sv
// rtl/lpf_decim_out.sv - decimate, round/saturate and buffer the FIR low-pass output
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_sample, in_en     signed filter output, valid when in_en=1
//   out_data, out_valid  head-of-FIFO word (0 when empty) and FIFO-not-empty
//   out_ready            consumer takes out_data at this edge
//   sat_flag             sticky: some word has been clamped since reset
//   drop_cnt             words lost to a full FIFO, saturating at 255
module lpf_decim_out #(
    parameter int IN_W  = lpf_pkg::IN_W,
    parameter int OUT_W = lpf_pkg::OUT_W,
    parameter int DECIM = 4,
    parameter int SHIFT = lpf_pkg::SHIFT,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_sample,
    input  logic                    in_en,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag,
    output logic [7:0]              drop_cnt
);

    import lpf_pkg::*;

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0]          phase;
    logic                   keep;
    logic signed [IN_W-1:0] s1_data;
    logic                   s1_vld;
    logic [OUT_W-1:0]       s2_word;
    logic                   s2_clamp;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;
    logic [OUT_W-1:0]       fifo_dout;

    assign keep = in_en && (phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (in_en) begin
            if (phase == PW'(DECIM - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= keep;
        end
        if (keep) begin
            s1_data <= in_sample;
        end
    end

    assign s2_word  = OUT_W'(round_sat(int'(s1_data), SHIFT, OUT_W));
    assign s2_clamp = round_clamps(int'(s1_data), SHIFT, OUT_W);

    // A pop in the same cycle frees the slot, so a full FIFO only drops when nobody is reading.
    assign fifo_pop  = !fifo_empty && out_ready;
    assign fifo_push = s1_vld && (!fifo_full || fifo_pop);
    assign drop      = s1_vld && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH(OUT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .din  (s2_word),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (s1_vld && s2_clamp) begin
                sat_flag <= 1'b1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lpf_decim_out.sv
// tb/tb_lpf_decim_out.sv - self-checking bench for lpf_decim_out
module tb_lpf_decim_out;

    localparam int DECIM = 4;
    localparam int SHIFT = 7;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] in_sample;
    logic               in_en;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               sat_flag;
    logic [7:0]         drop_cnt;

    lpf_decim_out dut (
        .clk      (clk),
        .rst      (rst),
        .in_sample(in_sample),
        .in_en    (in_en),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sat_flag (sat_flag),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: a queue of words, a count of enabled samples, one pending kept sample.
    int mq[$];
    int m_cnt;
    int m_s1;
    bit m_vld;
    bit m_sat;
    int m_drop;

    function automatic real ref_round(input int x);
        return $floor(real'(x) / (2.0 ** SHIFT) + 0.5);
    endfunction

    function automatic int ref_word(input int x);
        real v;
        v = ref_round(x);
        if (v > 127.0) v = 127.0;
        if (v < -128.0) v = -128.0;
        return int'(v);
    endfunction

    function automatic bit ref_clamp(input int x);
        real v;
        v = ref_round(x);
        return (v > 127.0) || (v < -128.0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop;
        bit was_full;
        if (rst) begin
            mq.delete();
            m_cnt  = 0;
            m_vld  = 0;
            m_sat  = 0;
            m_drop = 0;
        end else begin
            pop      = (mq.size() != 0) && out_ready;
            was_full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (m_vld) begin
                if (was_full && !pop) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mq.push_back(ref_word(m_s1));
                end
                if (ref_clamp(m_s1)) m_sat = 1;
            end
            if (in_en) begin
                m_vld = (m_cnt % DECIM) == 0;
                m_s1  = int'(in_sample);
                m_cnt++;
            end else begin
                m_vld = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_valid", int'(out_valid), int'(mq.size() != 0));
        check("model_data", int'(out_data), (mq.size() != 0) ? mq[0] : 0);
        check("model_sat", int'(sat_flag), int'(m_sat));
        check("model_drop", int'(drop_cnt), m_drop);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_en     = 1'b0;
        out_ready = 1'b0;
        in_sample = '0;
        step();
        rst = 1'b0;
    endtask

    // Expects exactly n words first, first+1, ... then an empty FIFO.
    task automatic drain(input int n, input int first);
        out_ready = 1'b1;
        in_en     = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("drain_valid", int'(out_valid), 1);
            check("drain_word", int'(out_data), first + k);
            step();
        end
        check("drain_empty", int'(out_valid), 0);
    endtask

    typedef struct {
        int x;
        int word;
        bit sat;
    } rnd_vec_t;

    initial begin
        rnd_vec_t vecs[11];
        int got[$];
        int first_v;
        int en_count;

        vecs[0]  = '{64, 1, 0};
        vecs[1]  = '{63, 0, 0};
        vecs[2]  = '{-64, 0, 0};
        vecs[3]  = '{-65, -1, 0};
        vecs[4]  = '{191, 1, 0};
        vecs[5]  = '{32767, 127, 1};
        vecs[6]  = '{-32768, -128, 1};
        vecs[7]  = '{100, 1, 0};
        vecs[8]  = '{-63, 0, 0};
        vecs[9]  = '{8000, 63, 0};
        vecs[10] = '{16383, 127, 1};

        // Reset state
        do_reset();
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_sat", int'(sat_flag), 0);
        check("reset_drop", int'(drop_cnt), 0);

        // Rounding / saturation vectors, one kept sample each
        for (int i = 0; i < 11; i++) begin
            do_reset();
            in_en     = 1'b1;
            in_sample = 16'(vecs[i].x);
            step();
            in_en = 1'b0;
            check("vec_latency_empty", int'(out_valid), 0);
            step();
            check("vec_valid", int'(out_valid), 1);
            check("vec_word", int'(out_data), vecs[i].word);
            check("vec_sat", int'(sat_flag), int'(vecs[i].sat));
        end

        // Sticky saturation across several words
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_en     = 1'b1;
            in_sample = (c == 0) ? 16'sd32767 : (c == 4) ? -16'sd32768 : 16'sd100;
            step();
        end
        in_en = 1'b0;
        step();
        check("sat_sticky", int'(sat_flag), 1);

        // Decimation order
        do_reset();
        out_ready = 1'b1;
        first_v   = -1;
        got.delete();
        for (int c = 0; c < 40; c++) begin
            in_en     = 1'b1;
            in_sample = 16'(128 * c);
            step();
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                got.push_back(int'(out_data));
            end
        end
        check("dec_first_valid", first_v, 1);
        check("dec_count", got.size(), 10);
        for (int i = 0; i < got.size(); i++) check("dec_word", got[i], 4 * i);
        check("dec_drop", int'(drop_cnt), 0);

        // Backpressure: 10 kept words into an 8-deep FIFO
        do_reset();
        for (int c = 0; c < 40; c++) begin
            in_en     = 1'b1;
            in_sample = 16'(128 * (c / 4 + 1));
            step();
            if (c >= 1) check("bp_valid_hold", int'(out_valid), 1);
        end
        check("bp_drop", int'(drop_cnt), 2);
        drain(8, 1);

        // Collision with a full FIFO, plus a 5-cycle in_en gap mid-stream
        do_reset();
        en_count = 0;
        while (en_count < 33) begin
            if (en_count == 10) begin
                in_en = 1'b0;
                for (int g = 0; g < 5; g++) step();
            end
            in_en     = 1'b1;
            in_sample = 16'(128 * (en_count / 4 + 1));
            step();
            en_count++;
        end
        check("col_full_valid", int'(out_valid), 1);
        in_en     = 1'b0;
        out_ready = 1'b1;
        step();
        check("col_no_drop", int'(drop_cnt), 0);
        drain(8, 2);

        // Reset mid-stream with 5 words held, sat_flag set and 3 drops
        do_reset();
        for (int c = 0; c < 42; c++) begin
            in_en     = 1'b1;
            in_sample = (c == 0) ? 16'sd32767 : 16'(128 * (c / 4 + 1));
            step();
        end
        in_en     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();
        out_ready = 1'b0;
        check("mid_drop", int'(drop_cnt), 3);
        check("mid_sat", int'(sat_flag), 1);
        rst   = 1'b1;
        in_en = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_sat", int'(sat_flag), 0);
        check("mid_rst_drop", int'(drop_cnt), 0);
        in_en     = 1'b1;
        in_sample = 16'sd640;
        step();
        in_en = 1'b0;
        step();
        check("mid_first_kept", int'(out_data), 5);
        check("mid_first_valid", int'(out_valid), 1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_en     = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            in_sample = 16'($urandom);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
